// File: rtl/gfx_pkg.sv
// Shared command format, opcodes and scheduler state encoding for the
// graphics command scheduler slice.
package gfx_pkg;

  localparam int unsigned GFX_WIDTH  = 640;
  localparam int unsigned GFX_HEIGHT = 480;

  localparam int unsigned CMD_W    = 51;
  localparam int unsigned ARG_LSB  = 0;
  localparam int unsigned BR_Y_LSB = 12;
  localparam int unsigned BR_X_LSB = 21;
  localparam int unsigned TL_Y_LSB = 31;
  localparam int unsigned TL_X_LSB = 40;
  localparam int unsigned OP_LSB   = 50;

  typedef enum logic {
    OP_FILL = 1'b0,
    OP_DRAW = 1'b1
  } gfx_op_e;

  typedef struct packed {
    gfx_op_e     opcode;
    logic [9:0]  tl_x;
    logic [8:0]  tl_y;
    logic [9:0]  br_x;
    logic [8:0]  br_y;
    logic [11:0] arg;
  } gfx_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_RELEASE
  } sched_state_e;

  function automatic gfx_cmd_t unpack_cmd(input logic [CMD_W-1:0] raw);
    gfx_cmd_t c;
    c.opcode = gfx_op_e'(raw[OP_LSB]);
    c.tl_x   = raw[TL_X_LSB +: 10];
    c.tl_y   = raw[TL_Y_LSB +: 9];
    c.br_x   = raw[BR_X_LSB +: 10];
    c.br_y   = raw[BR_Y_LSB +: 9];
    c.arg    = raw[ARG_LSB +: 12];
    return c;
  endfunction

  function automatic logic [CMD_W-1:0] pack_cmd(input gfx_cmd_t c);
    logic [CMD_W-1:0] raw;
    raw                    = '0;
    raw[OP_LSB]            = c.opcode;
    raw[TL_X_LSB +: 10]    = c.tl_x;
    raw[TL_Y_LSB +: 9]     = c.tl_y;
    raw[BR_X_LSB +: 10]    = c.br_x;
    raw[BR_Y_LSB +: 9]     = c.br_y;
    raw[ARG_LSB +: 12]     = c.arg;
    return raw;
  endfunction

endpackage

// File: rtl/gfx_cmd_fifo.sv
// Synchronous command FIFO; head word is always presented, the consumer
// registers it on the cycle it pops.
module gfx_cmd_fifo
  import gfx_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [CMD_W-1:0]         wr_data_i,
  input  logic                     pop_i,
  output logic [CMD_W-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  // DEPTH is a power of two, so the level MSB alone marks full.
  assign full_o    = level_q[AW];
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    level_d = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/gfx_cmd_scheduler.sv
// Two-requester round-robin command scheduler that queues rectangle commands
// and sequences a single graphics_processor through en/finish handshakes.
module gfx_cmd_scheduler
  import gfx_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned WIDTH  = GFX_WIDTH,
  parameter int unsigned HEIGHT = GFX_HEIGHT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [2*CMD_W-1:0]     req_cmd,
  output logic                   gp_en,
  output logic                   gp_opcode,
  output logic [9:0]             gp_tl_x,
  output logic [8:0]             gp_tl_y,
  output logic [9:0]             gp_br_x,
  output logic [8:0]             gp_br_y,
  output logic [11:0]            gp_arg,
  input  logic                   gp_finish,
  output logic                   cmd_done,
  output logic                   cmd_drop,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level
);

  sched_state_e     state_q, state_d;
  logic             rr_q, rr_d;
  logic             grant;
  logic             push, pop;
  logic             fifo_full, fifo_empty;
  logic [CMD_W-1:0] push_data, head_data;
  gfx_cmd_t         cmd_q, cmd_d;
  logic             cmd_ok;
  logic             done_q, done_d;
  logic             drop_q, drop_d;

  // A lone requester always wins; on contention the rr pointer decides.
  always_comb begin
    grant = rr_q;
    if (req_valid == 2'b01)      grant = 1'b0;
    else if (req_valid == 2'b10) grant = 1'b1;
    req_ready = '0;
    if ((|req_valid) && !fifo_full) req_ready[grant] = 1'b1;
    push      = |(req_valid & req_ready);
    push_data = grant ? req_cmd[2*CMD_W-1:CMD_W] : req_cmd[CMD_W-1:0];
    rr_d      = push ? ~grant : rr_q;
  end

  gfx_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (push),
    .wr_data_i (push_data),
    .pop_i     (pop),
    .rd_data_o (head_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (fifo_level)
  );

  assign cmd_ok = (cmd_q.tl_x <= cmd_q.br_x) &&
                  (cmd_q.tl_y <= cmd_q.br_y) &&
                  (32'(cmd_q.br_x) < WIDTH)  &&
                  (32'(cmd_q.br_y) < HEIGHT);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (!fifo_empty) state_d = ST_LOAD;
      ST_LOAD:    state_d = cmd_ok ? ST_RUN : ST_IDLE;
      ST_RUN:     if (gp_finish) state_d = ST_RELEASE;
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // gp_en comes purely from registered state and fields, so it rises in LOAD
  // for a good command and stays high through the finish cycle.
  always_comb begin
    pop    = 1'b0;
    gp_en  = 1'b0;
    done_d = 1'b0;
    drop_d = 1'b0;
    cmd_d  = cmd_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop   = 1'b1;
          cmd_d = unpack_cmd(head_data);
        end
      end
      ST_LOAD: begin
        gp_en  = cmd_ok;
        drop_d = !cmd_ok;
      end
      ST_RUN: begin
        gp_en  = 1'b1;
        done_d = gp_finish;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q   <= 1'b0;
      cmd_q  <= '0;
      done_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      rr_q   <= rr_d;
      cmd_q  <= cmd_d;
      done_q <= done_d;
      drop_q <= drop_d;
    end
  end

  assign gp_opcode = cmd_q.opcode;
  assign gp_tl_x   = cmd_q.tl_x;
  assign gp_tl_y   = cmd_q.tl_y;
  assign gp_br_x   = cmd_q.br_x;
  assign gp_br_y   = cmd_q.br_y;
  assign gp_arg    = cmd_q.arg;
  assign cmd_done  = done_q;
  assign cmd_drop  = drop_q;
  assign busy      = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_gfx_cmd_scheduler.sv
// Scoreboard bench for gfx_cmd_scheduler with a simple processor model.
module tb_gfx_cmd_scheduler;

  localparam int DEPTH    = 4;
  localparam int PROC_LAT = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [101:0] req_cmd;
  logic         gp_en, gp_opcode;
  logic [9:0]   gp_tl_x, gp_br_x;
  logic [8:0]   gp_tl_y, gp_br_y;
  logic [11:0]  gp_arg;
  logic         gp_finish;
  logic         cmd_done, cmd_drop, busy;
  logic [2:0]   fifo_level;

  logic         model_finish = 1'b0;
  logic         force_finish = 1'b0;
  logic [50:0]  gp_fields;

  assign gp_finish = model_finish | force_finish;
  assign gp_fields = {gp_opcode, gp_tl_x, gp_tl_y, gp_br_x, gp_br_y, gp_arg};

  always #5 clk = ~clk;

  gfx_cmd_scheduler #(
    .DEPTH  (DEPTH),
    .WIDTH  (640),
    .HEIGHT (480)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_cmd    (req_cmd),
    .gp_en      (gp_en),
    .gp_opcode  (gp_opcode),
    .gp_tl_x    (gp_tl_x),
    .gp_tl_y    (gp_tl_y),
    .gp_br_x    (gp_br_x),
    .gp_br_y    (gp_br_y),
    .gp_arg     (gp_arg),
    .gp_finish  (gp_finish),
    .cmd_done   (cmd_done),
    .cmd_drop   (cmd_drop),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  typedef struct {
    bit          drop;
    logic [50:0] cmd;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_done   = 0;
  int   n_drop   = 0;
  int   en_rises = 0;
  int   low_run  = 0;
  int   last_gap = -1;
  bit   bench_rr = 1'b0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endfunction

  function automatic logic [50:0] mk(input logic op, input int tlx, input int tly,
                                     input int brx, input int bry, input logic [11:0] arg);
    return {op, 10'(tlx), 9'(tly), 10'(brx), 9'(bry), arg};
  endfunction

  // Processor model: raises finish after PROC_LAT enabled cycles, holds it until en drops.
  int run_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (gp_en) begin
      run_cnt++;
      model_finish = (run_cnt >= PROC_LAT);
    end else begin
      run_cnt      = 0;
      model_finish = 1'b0;
    end
  end

  // Monitor: pops the scoreboard on every done/drop pulse and watches gp_en.
  logic        en_prev = 1'b0;
  logic [50:0] fields_prev = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      en_prev = 1'b0;
      low_run = 0;
    end else begin
      if (cmd_done || cmd_drop) begin
        exp_t e;
        chk("done_drop_exclusive", cmd_done & cmd_drop, 0);
        n_done += int'(cmd_done);
        n_drop += int'(cmd_drop);
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_pulse", {cmd_done, cmd_drop}, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_kind_drop", cmd_drop, e.drop);
          chk("sb_fields", gp_fields, e.cmd);
        end
      end
      if (gp_en && !en_prev) begin
        en_rises++;
        last_gap = low_run;
        chk("en_gap_min2", low_run >= 2, 1);
      end
      if (gp_en && en_prev) chk("fields_stable", gp_fields, fields_prev);
      if (!gp_en) low_run++;
      else        low_run = 0;
      en_prev     = gp_en;
      fields_prev = gp_fields;
    end
  end

  task automatic push(input int r, input logic [50:0] c, input bit drop);
    int n = 0;
    exp_t e;
    @(posedge clk); #1;
    req_valid    = 2'b00;
    req_valid[r] = 1'b1;
    req_cmd[r*51 +: 51] = c;
    @(negedge clk);
    while (!req_ready[r] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("push_accept", req_ready[r], 1);
    if (req_ready[r]) begin
      e.drop = drop;
      e.cmd  = c;
      exp_q.push_back(e);
      bench_rr = (r == 0);
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || exp_q.size() != 0) && n < 1000);
    chk({tag, "_drain"}, n < 1000, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n        = 1'b0;
    req_valid    = 2'b00;
    force_finish = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bench_rr = 1'b0;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int d0, r0, n;
    logic [50:0] c0 [6];
    logic [50:0] c1 [6];

    req_valid = 2'b00;
    req_cmd   = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gp_en", gp_en, 0);
    chk("rst_fields", gp_fields, 0);
    chk("rst_done_drop", {cmd_done, cmd_drop}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ready", req_ready, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // 1: single fill, 3-cycle latency to gp_en
    d0 = n_done;
    push(0, mk(1'b0, 0, 0, 3, 1, 12'hF00), 1'b0);
    @(negedge clk);
    chk("t1_en_low_idle", gp_en, 0);
    @(negedge clk);
    chk("t1_en_high_load", gp_en, 1);
    chk("t1_fields", gp_fields, {1'b0, 10'd0, 9'd0, 10'd3, 9'd1, 12'hF00});
    wait_idle("t1");
    chk("t1_one_done", n_done - d0, 1);
    chk("t1_busy_low", busy, 0);

    // 2: both requesters streaming, strict alternation, back-pressure when full
    do_reset();
    for (int k = 0; k < 6; k++) begin
      c0[k] = mk(1'b0, k, k, k + 2, k + 1, 12'h100 + 12'(k));
      c1[k] = mk(1'b1, 10 + k, 20 + k, 40 + k, 30 + k, 12'h200 + 12'(k));
    end
    begin
      int  i0 = 0, i1 = 0, guard = 0;
      bit  full_seen = 1'b0;
      bit  g, exp_g;
      exp_t e;
      while ((i0 < 6 || i1 < 6) && guard < 400) begin
        @(posedge clk); #1;
        req_valid = {i1 < 6, i0 < 6};
        if (i0 < 6) req_cmd[50:0]   = c0[i0];
        if (i1 < 6) req_cmd[101:51] = c1[i1];
        @(negedge clk);
        if (fifo_level == 3'd4) begin
          full_seen = 1'b1;
          chk("t2_ready_when_full", req_ready, 0);
        end
        if ((req_valid & req_ready) != 2'b00) begin
          chk("t2_ready_onehot", req_ready == 2'b11, 0);
          g     = req_ready[1];
          exp_g = (req_valid == 2'b11) ? bench_rr : req_valid[1];
          chk("t2_grant", g, exp_g);
          e.drop = 1'b0;
          e.cmd  = g ? c1[i1] : c0[i0];
          exp_q.push_back(e);
          if (g) i1++;
          else   i0++;
          bench_rr = ~g;
        end
        guard++;
      end
      chk("t2_all_accepted", guard < 400, 1);
      chk("t2_full_seen", full_seen, 1);
      @(posedge clk); #1;
      req_valid = 2'b00;
    end
    wait_idle("t2");

    // 3: two invalid rectangles dropped, then a valid one runs
    d0 = n_drop;
    r0 = en_rises;
    push(0, mk(1'b0, 5, 0, 4, 2, 12'h011), 1'b1);
    push(1, mk(1'b0, 0, 0, 10, 480, 12'h022), 1'b1);
    push(0, mk(1'b1, 1, 2, 30, 40, 12'h123), 1'b0);
    wait_idle("t3");
    chk("t3_drops", n_drop - d0, 2);
    chk("t3_en_rises", en_rises - r0, 1);

    // 4: back-to-back commands, gp_en low exactly two cycles between them
    r0 = en_rises;
    push(0, mk(1'b0, 100, 50, 120, 60, 12'h0A5), 1'b0);
    push(1, mk(1'b1, 200, 70, 210, 90, 12'h5A0), 1'b0);
    wait_idle("t4");
    chk("t4_en_rises", en_rises - r0, 2);
    chk("t4_gap", last_gap, 2);

    // 5: reset while running with three queued
    d0 = n_done;
    push(0, mk(1'b0, 1, 1, 2, 2, 12'h001), 1'b0);
    push(0, mk(1'b0, 3, 3, 4, 4, 12'h002), 1'b0);
    push(1, mk(1'b1, 5, 5, 6, 6, 12'h003), 1'b0);
    push(0, mk(1'b0, 7, 7, 8, 8, 12'h004), 1'b0);
    @(negedge clk);
    chk("t5_level3", fifo_level, 3);
    chk("t5_running", gp_en, 1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    bench_rr = 1'b0;
    @(negedge clk);
    chk("t5_en_low", gp_en, 0);
    chk("t5_level0", fifo_level, 0);
    chk("t5_busy0", busy, 0);
    repeat (20) @(negedge clk);
    chk("t5_no_done", n_done - d0, 0);
    push(1, mk(1'b1, 9, 9, 19, 19, 12'h777), 1'b0);
    wait_idle("t5");
    chk("t5_post_reset_done", n_done - d0, 1);

    // 6: stray finish in IDLE and RELEASE ignored; full-screen rectangle accepted
    d0 = n_done;
    @(posedge clk); #1 force_finish = 1'b1;
    repeat (2) @(posedge clk);
    #1 force_finish = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_idle_finish_ignored", n_done - d0, 0);
    chk("t6_idle_busy", busy, 0);
    push(0, mk(1'b1, 0, 0, 639, 479, 12'hABC), 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_done && n < 100);
    chk("t6_done_seen", cmd_done, 1);
    force_finish = 1'b1;
    @(posedge clk); #1 force_finish = 1'b0;
    wait_idle("t6");
    repeat (3) @(negedge clk);
    chk("t6_single_done", n_done - d0, 1);
    chk("t6_busy_low", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
